prog_loader: RTL and testbench

- Upstream feeder for the Simplez 512x12 main memory.
- Receives a program image as a byte stream from an external UART receiver and assembles 12-bit words.
- Drives the memory write port (addr, wr, data_in) sequentially and holds the CPU in reset until the image is fully written.
- Memory samples on the falling edge; this block launches all memory-side outputs on the rising edge.

---
 rtl/simplez_pkg.sv | 19 +
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 108 ++++++++++
 tb/tb_prog_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplez_pkg.sv
// simplez_pkg: constants and types shared by the Simplez memory, CPU and program loader.
package simplez_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 12;
  localparam logic [7:0] SYNC_BYTE = 8'h4C;

  typedef enum logic [2:0] {
    IDLE,
    LEN_H,
    LEN_L,
    WHI,
    WLO,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: UART byte input plus memory write port and CPU control of the program loader.
interface prog_loader_if;
  import simplez_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_rstn;

  modport master (
    input  rx_data, rx_valid,
    output mem_addr, mem_data, mem_wr, busy, done, error, cpu_rstn
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_addr, mem_data, mem_wr, busy, done, error, cpu_rstn
  );

endinterface

// File: rtl/prog_loader.sv
// prog_loader: turns a UART byte frame into sequential 12-bit Simplez memory writes, holding the CPU in reset meanwhile.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte before the CPU is released.
module prog_loader
  import simplez_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rstn,
  prog_loader_if.master bus
);

  loader_state_t   state, next_state;
  logic [3:0]      nibble;
  logic            len_hi;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] wcount;
  logic            last_word;
  logic            new_frame;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign last_word    = (wcount + (ADDR_W+1)'(1)) == n_words;
  assign new_frame    = (next_state == LEN_H) && (state != LEN_H);
  assign bus.busy     = !(state inside {IDLE, DONE, ERROR});
  assign bus.error    = (state == ERROR);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) next_state = LEN_H;
      LEN_H:
        if (bus.rx_valid) next_state = (bus.rx_data[7:1] != '0) ? ERROR : LEN_L;
      LEN_L:
        if (bus.rx_valid) next_state = WHI;
      WHI:
        if (bus.rx_valid) next_state = (bus.rx_data[7:4] != '0) ? ERROR : WLO;
      WLO:
        if (bus.rx_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          next_state = last_word ? CHK : WHI;
`else
          next_state = last_word ? DONE : WHI;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK:
        if (bus.rx_valid) next_state = (bus.rx_data == csum) ? DONE : ERROR;
`endif
      DONE, ERROR:
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) next_state = LEN_H;
      default:
        next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // cpu_rstn rises only after a full cycle in DONE, so the last write completes before the CPU runs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.mem_addr <= BASE_ADDR;
      bus.mem_data <= '0;
      bus.mem_wr   <= 1'b0;
      bus.done     <= 1'b0;
      bus.cpu_rstn <= 1'b0;
      nibble       <= '0;
      len_hi       <= 1'b0;
      n_words      <= '0;
      wcount       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      bus.mem_wr   <= 1'b0;
      bus.done     <= (state == DONE) && !bus.cpu_rstn;
      bus.cpu_rstn <= (state == DONE) && (next_state == DONE);
      if (new_frame)       bus.mem_addr <= BASE_ADDR;
      else if (bus.mem_wr) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
      if (bus.rx_valid) begin
        case (state)
          LEN_H: len_hi <= bus.rx_data[0];
          LEN_L: begin
            n_words <= {({len_hi, bus.rx_data} == '0), len_hi, bus.rx_data};
            wcount  <= '0;
          end
          WHI: nibble <= bus.rx_data[3:0];
          WLO: begin
            bus.mem_data <= {nibble, bus.rx_data};
            bus.mem_wr   <= 1'b1;
            wcount       <= wcount + (ADDR_W+1)'(1);
          end
          default: ;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state == LEN_H) csum <= bus.rx_data;
        else if (state inside {LEN_L, WHI, WLO}) csum <= csum + bus.rx_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frame stimulus checked against a queue-based model of the expected memory image.
module tb_prog_loader;
  import simplez_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  prog_loader_if bus();

  prog_loader #(.BASE_ADDR('0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  logic [DATA_W-1:0] word_q[$];
  logic [7:0]        frame_q[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_wr_cyc = 0;
  int   wr_run_err = 0;
  int   done_run_err = 0;
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;

  // Records every write and done pulse, flagging any that last longer than one cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.mem_wr) begin
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_data);
        last_wr_cyc = cyc;
        if (prev_wr) wr_run_err++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        if (prev_done) done_run_err++;
      end
      prev_wr   = bus.mem_wr;
      prev_done = bus.done;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_run_err   = 0;
    done_run_err = 0;
  endtask

  task automatic random_words(input int n);
    word_q.delete();
    for (int i = 0; i < n; i++) word_q.push_back(DATA_W'($urandom));
  endtask

  // Frame = sync, length, then HI/LO byte pairs; checksum covers every byte after sync.
  task automatic build_frame();
    logic [8:0] len;
    logic [7:0] sum;
    len = 9'(word_q.size());
    frame_q.delete();
    frame_q.push_back(SYNC_BYTE);
    frame_q.push_back({7'b0, len[8]});
    frame_q.push_back(len[7:0]);
    foreach (word_q[i]) begin
      frame_q.push_back({4'b0, word_q[i][11:8]});
      frame_q.push_back(word_q[i][7:0]);
    end
    sum = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) sum = sum + frame_q[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    frame_q.push_back(sum);
`endif
  endtask

  task automatic send_frame(input int maxgap);
    @(posedge clk);
    #1;
    foreach (frame_q[i]) begin
      int gap;
      gap = $urandom_range(maxgap, 0);
      bus.rx_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      bus.rx_data  = frame_q[i];
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #22;
    tests++; if (bus.mem_addr !== '0)  begin fails++; $display("[TB] FAIL reset mem_addr: got %0h expected 0", bus.mem_addr); end
    tests++; if (bus.mem_data !== '0)  begin fails++; $display("[TB] FAIL reset mem_data: got %0h expected 0", bus.mem_data); end
    tests++; if (bus.mem_wr !== 1'b0)  begin fails++; $display("[TB] FAIL reset mem_wr: got %b expected 0", bus.mem_wr); end
    tests++; if (bus.busy !== 1'b0)    begin fails++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0)    begin fails++; $display("[TB] FAIL reset done: got %b expected 0", bus.done); end
    tests++; if (bus.error !== 1'b0)   begin fails++; $display("[TB] FAIL reset error: got %b expected 0", bus.error); end
    tests++; if (bus.cpu_rstn !== 1'b0) begin fails++; $display("[TB] FAIL reset cpu_rstn: got %b expected 0", bus.cpu_rstn); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_words();
    int d0;
    clear_mon();
    d0 = done_cnt;
    word_q.delete();
    word_q.push_back(12'o0100);
    word_q.push_back(12'o7000);
    build_frame();
    send_frame(2);
    repeat (5) @(negedge clk);
    tests++; if (wr_addr_q.size() != 2) begin fails++; $display("[TB] FAIL two_words count: got %0d expected 2", wr_addr_q.size()); end
    else begin
      tests++; if (wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== 12'o0100)
        begin fails++; $display("[TB] FAIL two_words word0: got addr %0d data %o expected addr 0 data 0100", wr_addr_q[0], wr_data_q[0]); end
      tests++; if (wr_addr_q[1] !== 9'd1 || wr_data_q[1] !== 12'o7000)
        begin fails++; $display("[TB] FAIL two_words word1: got addr %0d data %o expected addr 1 data 7000", wr_addr_q[1], wr_data_q[1]); end
    end
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("[TB] FAIL two_words done: got %0d pulses expected 1", done_cnt - d0); end
`ifndef PROG_LOADER_CHECKSUM_EN
    tests++; if (done_cyc != last_wr_cyc + 1) begin fails++; $display("[TB] FAIL two_words done_timing: got cycle %0d expected %0d", done_cyc, last_wr_cyc + 1); end
`endif
    tests++; if (bus.cpu_rstn !== 1'b1) begin fails++; $display("[TB] FAIL two_words cpu_rstn: got %b expected 1", bus.cpu_rstn); end
    tests++; if (bus.mem_addr !== 9'd2) begin fails++; $display("[TB] FAIL two_words mem_addr: got %0d expected 2", bus.mem_addr); end
    tests++; if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin fails++; $display("[TB] FAIL two_words status: got busy %b error %b expected 0 0", bus.busy, bus.error); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int n, d0, errs;
      n = $urandom_range(24, 1);
      random_words(n);
      word_q[$urandom_range(n - 1, 0)][7:0] = SYNC_BYTE;
      clear_mon();
      d0 = done_cnt;
      frame_q.delete();
      frame_q.push_back(8'($urandom_range(8'h4B, 0)));
      send_frame(2);
      build_frame();
      send_frame(3);
      repeat (6) @(negedge clk);
      errs = (wr_addr_q.size() != n) ? 1 : 0;
      foreach (word_q[i])
        if (i < wr_addr_q.size())
          if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== word_q[i]) errs++;
      tests++; if (errs != 0) begin fails++; $display("[TB] FAIL random_frame%0d image: got %0d writes with %0d bad expected %0d clean writes", f, wr_addr_q.size(), errs, n); end
      tests++; if (done_cnt != d0 + 1 || bus.cpu_rstn !== 1'b1) begin fails++; $display("[TB] FAIL random_frame%0d done: got pulses %0d cpu_rstn %b expected 1 1", f, done_cnt - d0, bus.cpu_rstn); end
      tests++; if (bus.mem_addr !== ADDR_W'(n)) begin fails++; $display("[TB] FAIL random_frame%0d mem_addr: got %0d expected %0d", f, bus.mem_addr, n); end
    end
  endtask

  task automatic test_full_load();
    int d0, errs;
    random_words(512);
    clear_mon();
    d0 = done_cnt;
    build_frame();
    send_frame(0);
    repeat (6) @(negedge clk);
    errs = (wr_addr_q.size() != 512) ? 1 : 0;
    foreach (word_q[i])
      if (i < wr_addr_q.size())
        if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== word_q[i]) errs++;
    tests++; if (errs != 0) begin fails++; $display("[TB] FAIL full_load image: got %0d writes with %0d bad expected 512 clean writes", wr_addr_q.size(), errs); end
    tests++; if (bus.mem_addr !== '0) begin fails++; $display("[TB] FAIL full_load wrap: got mem_addr %0d expected 0", bus.mem_addr); end
    tests++; if (done_cnt != d0 + 1 || bus.cpu_rstn !== 1'b1) begin fails++; $display("[TB] FAIL full_load done: got pulses %0d cpu_rstn %b expected 1 1", done_cnt - d0, bus.cpu_rstn); end
    tests++; if (wr_run_err != 0) begin fails++; $display("[TB] FAIL full_load wr_width: got %0d long pulses expected 0", wr_run_err); end
  endtask

  task automatic test_protocol_error();
    logic [7:0] full_q[$];
    clear_mon();
    frame_q = '{8'h4C, 8'h00, 8'h01, 8'hF0};
    send_frame(1);
    repeat (3) @(negedge clk);
    tests++; if (bus.error !== 1'b1 || bus.cpu_rstn !== 1'b0) begin fails++; $display("[TB] FAIL proto_nibble flags: got error %b cpu_rstn %b expected 1 0", bus.error, bus.cpu_rstn); end
    tests++; if (wr_addr_q.size() != 0 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL proto_nibble writes: got %0d writes busy %b expected 0 0", wr_addr_q.size(), bus.busy); end
    random_words(3);
    build_frame();
    full_q = frame_q;
    frame_q = '{8'h4C};
    send_frame(0);
    @(negedge clk);
    tests++; if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL proto_clear: got error %b busy %b expected 0 1", bus.error, bus.busy); end
    frame_q = full_q[1:$];
    send_frame(1);
    repeat (5) @(negedge clk);
    tests++; if (wr_data_q.size() != 3 || wr_data_q[0] !== word_q[0] || wr_data_q[2] !== word_q[2] || wr_addr_q[2] !== 9'd2)
      begin fails++; $display("[TB] FAIL proto_reload: got %0d writes expected 3 matching words at 0..2", wr_data_q.size()); end
    tests++; if (bus.cpu_rstn !== 1'b1 || bus.error !== 1'b0) begin fails++; $display("[TB] FAIL proto_reload flags: got cpu_rstn %b error %b expected 1 0", bus.cpu_rstn, bus.error); end
    frame_q = '{8'h4C, 8'h02};
    send_frame(0);
    repeat (2) @(negedge clk);
    tests++; if (bus.error !== 1'b1 || bus.cpu_rstn !== 1'b0) begin fails++; $display("[TB] FAIL proto_len: got error %b cpu_rstn %b expected 1 0", bus.error, bus.cpu_rstn); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic [7:0]        stream_q[$];
    int d0, errs, na, nb;
    clear_mon();
    d0 = done_cnt;
    na = $urandom_range(10, 1);
    nb = $urandom_range(10, 1);
    random_words(na);
    foreach (word_q[i]) begin exp_q.push_back(word_q[i]); exp_a.push_back(ADDR_W'(i)); end
    build_frame();
    stream_q = frame_q;
    random_words(nb);
    foreach (word_q[i]) begin exp_q.push_back(word_q[i]); exp_a.push_back(ADDR_W'(i)); end
    build_frame();
    frame_q = {stream_q, frame_q};
    send_frame(0);
    repeat (6) @(negedge clk);
    errs = (wr_data_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i])
      if (i < wr_data_q.size())
        if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_q[i]) errs++;
    tests++; if (errs != 0) begin fails++; $display("[TB] FAIL back_to_back image: got %0d writes with %0d bad expected %0d", wr_data_q.size(), errs, exp_q.size()); end
    tests++; if (done_cnt != d0 + 2) begin fails++; $display("[TB] FAIL back_to_back done: got %0d pulses expected 2", done_cnt - d0); end
    tests++; if (wr_run_err != 0 || done_run_err != 0) begin fails++; $display("[TB] FAIL back_to_back widths: got wr %0d done %0d long pulses expected 0 0", wr_run_err, done_run_err); end
  endtask

  task automatic test_midload_reset();
    word_q.delete();
    for (int i = 0; i < 5; i++) word_q.push_back(DATA_W'($urandom_range(4095, 1)));
    clear_mon();
    build_frame();
    frame_q = frame_q[0:8];
    send_frame(1);
    repeat (2) @(negedge clk);
    tests++; if (wr_addr_q.size() != 3 || bus.mem_addr !== 9'd3) begin fails++; $display("[TB] FAIL midload partial: got %0d writes mem_addr %0d expected 3 3", wr_addr_q.size(), bus.mem_addr); end
    #2 rstn = 1'b0;
    #1;
    tests++; if (bus.mem_addr !== '0 || bus.mem_data !== '0 || bus.mem_wr !== 1'b0)
      begin fails++; $display("[TB] FAIL midload reset_mem: got addr %0d data %0h wr %b expected 0 0 0", bus.mem_addr, bus.mem_data, bus.mem_wr); end
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.cpu_rstn !== 1'b0)
      begin fails++; $display("[TB] FAIL midload reset_ctl: got busy %b done %b error %b cpu_rstn %b expected 0 0 0 0", bus.busy, bus.done, bus.error, bus.cpu_rstn); end
    @(negedge clk);
    rstn = 1'b1;
    clear_mon();
    random_words(2);
    build_frame();
    send_frame(1);
    repeat (5) @(negedge clk);
    tests++; if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== word_q[0] || wr_data_q[1] !== word_q[1])
      begin fails++; $display("[TB] FAIL midload fresh: got %0d writes expected 2 from addr 0", wr_addr_q.size()); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    clear_mon();
    d0 = done_cnt;
    frame_q = '{8'h4C, 8'h00, 8'h01, 8'h00, 8'h05, 8'h06};
    send_frame(1);
    repeat (4) @(negedge clk);
    tests++; if (done_cnt != d0 + 1 || bus.cpu_rstn !== 1'b1 || bus.error !== 1'b0)
      begin fails++; $display("[TB] FAIL checksum_good: got pulses %0d cpu_rstn %b error %b expected 1 1 0", done_cnt - d0, bus.cpu_rstn, bus.error); end
    clear_mon();
    d0 = done_cnt;
    frame_q = '{8'h4C, 8'h00, 8'h01, 8'h00, 8'h05, 8'h07};
    send_frame(1);
    repeat (4) @(negedge clk);
    tests++; if (done_cnt != d0 || bus.cpu_rstn !== 1'b0 || bus.error !== 1'b1)
      begin fails++; $display("[TB] FAIL checksum_bad: got pulses %0d cpu_rstn %b error %b expected 0 0 1", done_cnt - d0, bus.cpu_rstn, bus.error); end
    tests++; if (wr_data_q.size() != 1 || wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== 12'o0005)
      begin fails++; $display("[TB] FAIL checksum_bad write: got %0d writes expected 1 of 0005 at addr 0", wr_data_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_random_frames();
    test_full_load();
    test_protocol_error();
    test_back_to_back();
    test_midload_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
